// File: rtl/glb_read_capture.sv
// Stream sink for memory-core tile tests: captures a valid/ready word stream into a local
// buffer in arrival order, reports completion, underrun and overflow, and offers a read port.
module glb_read_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int TX_SIZE    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  done_in,
    input  logic [7:0]            stall_period,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  underrun,
    output logic                  overflow,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    if (TX_SIZE < 1 || TX_SIZE > DEPTH) begin : g_bad_tx_size
        $error("glb_read_capture: TX_SIZE must lie in 1..DEPTH");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("glb_read_capture: ADDR_WIDTH too small for DEPTH");
    end

    localparam logic [ADDR_WIDTH:0] TX_COUNT = (ADDR_WIDTH + 1)'(TX_SIZE);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                state, state_next;
    logic                  flush_q;
    logic [7:0]            stall_cnt, stall_next;
    logic [7:0]            stall_last;
    logic [ADDR_WIDTH:0]   count_next, count_inc;
    logic                  underrun_next, overflow_next, ready_next;
    logic                  xfer, wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign stall_last = stall_period - 8'd1;
    assign count_inc  = count + ONE;
    assign xfer       = (state == ST_CAPTURE) && valid_in && ready_out;
    assign done       = (state == ST_DONE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next    = state;
        count_next    = count;
        underrun_next = underrun;
        overflow_next = overflow;
        stall_next    = stall_cnt;
        wr_en         = 1'b0;

        if (flush) begin
            // Restart dominates everything, including a transfer in the same cycle.
            state_next    = ST_FLUSH;
            count_next    = '0;
            underrun_next = 1'b0;
            overflow_next = 1'b0;
            stall_next    = 8'd0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_FLUSH: begin
                    // flush is low here, so flush_q alone marks the falling edge.
                    if (flush_q) begin
                        state_next = ST_CAPTURE;
                        stall_next = 8'd0;
                    end
                end
                ST_CAPTURE: begin
                    stall_next = (stall_period == 8'd0 || stall_cnt == stall_last) ?
                                 8'd0 : stall_cnt + 8'd1;
                    if (xfer) begin
                        wr_en      = 1'b1;
                        count_next = count_inc;
                    end
                    if (xfer && count_inc == TX_COUNT) begin
                        state_next = ST_DONE;
                    end else if (done_in) begin
                        state_next    = ST_DONE;
                        underrun_next = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (valid_in) overflow_next = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // ready_out is a register fed only from state, so valid_in never reaches it combinationally.
        ready_next = (state_next == ST_CAPTURE) &&
                     (stall_period == 8'd0 || stall_next != stall_last);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_q   <= 1'b0;
            stall_cnt <= 8'd0;
            count     <= '0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            ready_out <= 1'b0;
        end else begin
            state     <= state_next;
            flush_q   <= flush;
            stall_cnt <= stall_next;
            count     <= count_next;
            underrun  <= underrun_next;
            overflow  <= overflow_next;
            ready_out <= ready_next;
        end
    end

    // NOTE: the buffer has no reset; clearing a RAM would defeat memory inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count[ADDR_WIDTH-1:0]] <= data_in;
    end

    // Read-before-write: a same-cycle read of the address being written returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_glb_read_capture.sv
// Self-checking bench for glb_read_capture: scenario table, corner-case sequences, and
// randomized traffic checked against a transaction-level reference model.
module tb_glb_read_capture;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int TX    = 32;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          flush        = 1'b0;
    logic [DW-1:0] data_in      = '0;
    logic          valid_in     = 1'b0;
    logic          done_in      = 1'b0;
    logic [7:0]    stall_period = '0;
    logic [AW-1:0] rd_addr      = '0;
    logic          ready_out, done, underrun, overflow;
    logic [AW:0]   count;
    logic [DW-1:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;

    glb_read_capture #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TX_SIZE(TX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .valid_in(valid_in), .ready_out(ready_out), .done_in(done_in),
        .stall_period(stall_period), .count(count), .done(done),
        .underrun(underrun), .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // One full run: inputs, then the expected end state derived by hand from the rules.
    typedef struct {
        logic [15:0] base;
        int          sp;
        int          end_after;
        bit          done_last;
        int          exp_count;
        bit          exp_underrun;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[7];

    typedef enum {M_IDLE, M_FLUSH, M_CAP, M_DONE} mphase_t;

    // Reference model state
    mphase_t       m_phase;
    int            m_caps;
    int            m_count;
    bit            m_und, m_ovf, m_ready, m_flush_prev, m_rd_known;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int idx;
        int cyc;
        bit will;
        bit exp_rdy;
        stall_period = 8'(v.sp);
        valid_in     = 1'b0;
        done_in      = 1'b0;
        flush_pulse();
        idx = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            exp_rdy = (v.sp == 0) || ((cyc % v.sp) != v.sp - 1);
            check({tag, "_ready"}, 32'(ready_out), 32'(exp_rdy));
            if (v.end_after != 0 && idx == v.end_after) begin
                valid_in = 1'b0;
                done_in  = 1'b1;
            end else begin
                valid_in = 1'b1;
                data_in  = v.base + 16'(idx);
                done_in  = v.done_last && (idx == TX - 1) && (ready_out === 1'b1);
            end
            will = valid_in && (ready_out === 1'b1);
            tick();
            cyc++;
            if (will) idx++;
        end
        valid_in = 1'b0;
        done_in  = 1'b0;
        check({tag, "_cycles"},   32'(cyc),       32'(v.exp_cycles));
        check({tag, "_done"},     32'(done),      32'd1);
        check({tag, "_count"},    32'(count),     32'(v.exp_count));
        check({tag, "_underrun"}, 32'(underrun),  32'(v.exp_underrun));
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_ready_off"}, 32'(ready_out), 32'd0);
        for (int a = 0; a < v.exp_count; a++) begin
            rd_addr = AW'(a);
            tick();
            check($sformatf("%s_mem%0d", tag, a), 32'(rd_data), 32'(v.base + 16'(a)));
        end
    endtask

    task automatic model_reset();
        m_phase      = M_IDLE;
        m_caps       = 0;
        m_count      = 0;
        m_und        = 1'b0;
        m_ovf        = 1'b0;
        m_ready      = 1'b0;
        m_flush_prev = 1'b0;
        m_rd_known   = 1'b0;
        m_rd         = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    endtask

    // Advances the model across one clock edge with the given inputs.
    task automatic model_step(input bit f, input bit v, input logic [DW-1:0] d,
                              input bit di, input int sp, input int ra);
        bit xfer;
        m_rd_known = m_known[ra];
        m_rd       = m_mem[ra];
        xfer = (m_phase == M_CAP) && v && m_ready && !f;
        if (f) begin
            m_phase = M_FLUSH;
            m_count = 0;
            m_und   = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                M_FLUSH: if (m_flush_prev) begin
                    m_phase = M_CAP;
                    m_caps  = 0;
                end
                M_CAP: begin
                    m_caps++;
                    if (xfer) begin
                        m_mem[m_count]   = d;
                        m_known[m_count] = 1'b1;
                        m_count++;
                    end
                    if (xfer && m_count == TX) m_phase = M_DONE;
                    else if (di) begin
                        m_phase = M_DONE;
                        m_und   = 1'b1;
                    end
                end
                M_DONE: if (v) m_ovf = 1'b1;
                default: ;
            endcase
        end
        m_flush_prev = f;
        m_ready = (m_phase == M_CAP) && (sp == 0 || (m_caps % sp) != sp - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sp_cur;
        bit f, v, di;
        logic [DW-1:0] d;
        int ra;

        vecs[0] = '{16'h0000, 0, 0,  1'b0, 32, 1'b0, 32};
        vecs[1] = '{16'h0000, 4, 0,  1'b0, 32, 1'b0, 42};
        vecs[2] = '{16'h0100, 0, 10, 1'b0, 10, 1'b1, 11};
        vecs[3] = '{16'h0200, 0, 0,  1'b1, 32, 1'b0, 32};
        vecs[4] = '{16'h0300, 4, 10, 1'b0, 10, 1'b1, 14};
        vecs[5] = '{16'h0400, 3, 0,  1'b1, 32, 1'b0, 47};
        vecs[6] = '{16'h0500, 2, 0,  1'b0, 32, 1'b0, 63};

        // Reset state
        tick();
        tick();
        check("rst_ready",    32'(ready_out), 32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_underrun", 32'(underrun),  32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_count",    32'(count),     32'd0);
        check("rst_rd_data",  32'(rd_data),   32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(ready_out), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Overflow in DONE, then restart with a new data pattern
        run_vec(vecs[0], "ovf_pre");
        valid_in = 1'b1;
        data_in  = 16'hDEAD;
        repeat (3) tick();
        check("ovf_flag",  32'(overflow),  32'd1);
        check("ovf_count", 32'(count),     32'd32);
        check("ovf_ready", 32'(ready_out), 32'd0);
        check("ovf_done",  32'(done),      32'd1);
        valid_in = 1'b0;
        rd_addr  = AW'(31);
        tick();
        check("ovf_mem31", 32'(rd_data), 32'h001F);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("restart_overflow", 32'(overflow), 32'd0);
        check("restart_count",    32'(count),    32'd0);
        check("restart_done",     32'(done),     32'd0);
        tick();
        run_vec('{16'hA000, 0, 0, 1'b0, 32, 1'b0, 32}, "restart");

        // Asynchronous reset in the middle of a run
        stall_period = 8'd0;
        flush_pulse();
        valid_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 16'h0700 + 16'(i);
            tick();
        end
        check("mid_count", 32'(count),     32'd7);
        check("mid_ready", 32'(ready_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready_out), 32'd0);
        check("async_rst_count", 32'(count),     32'd0);
        check("async_rst_done",  32'(done),      32'd0);
        valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        run_vec('{16'h0800, 0, 0, 1'b0, 32, 1'b0, 32}, "post_reset");

        // Randomized traffic against the reference model
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        done_in  = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        sp_cur       = 0;
        stall_period = 8'd0;
        for (int c = 0; c < 4000; c++) begin
            f = ($urandom_range(199) < 3);
            if (f) begin
                case ($urandom_range(4))
                    0: sp_cur = 0;
                    1: sp_cur = 1;
                    2: sp_cur = 2;
                    3: sp_cur = 3;
                    default: sp_cur = 5;
                endcase
            end
            v  = ($urandom_range(99) < 70);
            di = ($urandom_range(99) < 2);
            d  = DW'($urandom);
            ra = int'($urandom_range(47));
            flush        = f;
            valid_in     = v;
            done_in      = di;
            data_in      = d;
            stall_period = 8'(sp_cur);
            rd_addr      = AW'(ra);
            model_step(f, v, d, di, sp_cur, ra);
            tick();
            check("rnd_ready",    32'(ready_out), 32'(m_ready));
            check("rnd_count",    32'(count),     32'(m_count));
            check("rnd_done",     32'(done),      32'(m_phase == M_DONE));
            check("rnd_underrun", 32'(underrun),  32'(m_und));
            check("rnd_overflow", 32'(overflow),  32'(m_ovf));
            if (m_rd_known) check("rnd_rd_data", 32'(rd_data), 32'(m_rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/glb_read_capture.md
Name: glb_read_capture

Overview:
- Synthesizable stream sink for memory-core tile tests; the downstream partner of the GLB write stream source.
- Accepts a 16-bit valid/ready stream from the core's output, stores words in order into a local buffer, and counts transfers.
- Signals completion once TX_SIZE words are captured.
- Can insert periodic backpressure, and exposes a registered read port for the checker.

Parameters:
- DATA_WIDTH, 16, stream word width.
- DEPTH, 1024, capture buffer entries.
- ADDR_WIDTH, 10, log2(DEPTH).
- TX_SIZE, 32, words expected per run. Must satisfy 1 <= TX_SIZE <= DEPTH; the design checks this at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  run restart; capture arms on the falling edge.
- data_in  input  DATA_WIDTH  stream data from the core.
- valid_in  input  1  stream valid.
- ready_out  output  1  sink ready; a transfer occurs when valid_in && ready_out.
- done_in  input  1  upstream end-of-stream indication.
- stall_period  input  8  0 = never stall; N > 0 = ready_out low one cycle in every N capture cycles.
- count  output  ADDR_WIDTH+1  words captured this run.
- done  output  1  run complete.
- underrun  output  1  sticky; upstream ended before TX_SIZE words.
- overflow  output  1  sticky; valid_in high while in DONE.
- rd_addr  input  ADDR_WIDTH  checker read address.
- rd_data  output  DATA_WIDTH  buffer contents at rd_addr.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - ready_out, done, underrun, overflow = 0; count = 0; stall counter = 0; rd_data = 0.
  - Buffer contents are not reset.
- States: IDLE, FLUSH, CAPTURE, DONE.
- Edge detection: flush_q is flush registered. A falling edge is flush_q && !flush.
- Transitions:
  - Any state: flush = 1 -> FLUSH next cycle; count, done, underrun, overflow and the stall counter clear.
  - FLUSH: falling edge of flush -> CAPTURE.
  - CAPTURE: reaching TX_SIZE or an upstream end -> DONE (details below).
  - DONE: held until the next flush.
- ready_out:
  - Registered; 0 in IDLE, FLUSH and DONE.
  - In CAPTURE: 1 when stall_period == 0.
  - Otherwise a stall counter runs 0..stall_period-1 and wraps, advancing every CAPTURE cycle. ready_out = 0 when the counter equals stall_period-1, else 1. The counter is 0 on entry to CAPTURE.
  - ready_out is independent of valid_in; no combinational path from valid_in to ready_out.
- Transfer (CAPTURE, valid_in && ready_out):
  - mem[count] <= data_in; count <= count + 1.
  - At most one word per cycle; words are stored in arrival order starting at address 0.
- Completion:
  - The transfer that makes count == TX_SIZE moves the FSM to DONE. done = 1 and ready_out = 0 from the next cycle.
  - No further writes in DONE.
- Upstream end:
  - done_in = 1 in CAPTURE with no transfer making count reach TX_SIZE in that cycle -> DONE with underrun = 1.
  - A transfer in the same cycle as done_in is still written.
  - done_in together with the final (TX_SIZE-th) transfer -> DONE, underrun = 0.
- overflow: set when valid_in = 1 in DONE. Sticky until flush or reset.
- Read port: rd_data <= mem[rd_addr] every cycle in every state, 1-cycle latency. Reading an address in the same cycle it is written returns the old contents.
- Simultaneous events:
  - flush high during a transfer: flush wins, nothing is written, count clears.
  - Reset mid-run: everything returns to IDLE immediately, without waiting for a clock edge.
- Widths: count is ADDR_WIDTH+1 bits so that count == DEPTH is representable. The count never exceeds TX_SIZE.

Test Plan:
- Basic run: reset, flush pulse, then upstream drives 0x0000..0x001F with valid held high, stall_period = 0 -> 32 transfers on 32 consecutive cycles; done = 1 one cycle after the 32nd; rd_addr = 5 returns 0x0005 one cycle later.
- Backpressure: same stream with stall_period = 4 -> ready_out low every 4th capture cycle; all 32 words captured in order; done after the last word; count = 32.
- Early end: done_in asserted after 10 words -> DONE with count = 10 and underrun = 1; mem[0..9] correct.
- done_in with the final word: done_in in the same cycle as the 32nd transfer -> done = 1, underrun = 0, count = 32.
- Overflow and restart:
  - valid_in held high in DONE -> overflow = 1 and no writes.
  - A new flush pulse clears count, done and overflow; a second run of 0xA000..0xA01F overwrites mem[0..31].
- Reset mid-run: rst_n low after 7 words -> ready_out, done and count are 0 immediately (asynchronously). After release, a flush then a full run completes normally with count = 32.
